// File: rtl/nibble_seq_pkg.sv
// nibble_seq_pkg
// Shared definitions for the nibble sequencer: the FSM state type, the ALU
// opcode that enables carry chaining, and the width helper for the nibble
// index counter.
package nibble_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU opcode (with l=0) that is treated as a wide addition.
  localparam logic [1:0] ALUOP_ADD = 2'b10;

  // Ceiling log2, clamped to at least 1 so a single-nibble build still gets
  // a legal one-bit index.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nib_sel.sv
// nib_sel
// NIBBLES-to-1 mux that picks one 4-bit slice out of a wide word.
// Ports:
//   word  in  4*NIBBLES  source word, nibble 0 in the low bits
//   sel   in  IDX_W      nibble index
//   nib   out 4          selected nibble (0 if sel is out of range)
module nib_sel
  import nibble_seq_pkg::*;
#(
  parameter int  NIBBLES = 4,
  localparam int IDX_W   = clog2(NIBBLES)
) (
  input  logic [4*NIBBLES-1:0] word,
  input  logic [IDX_W-1:0]     sel,
  output logic [3:0]           nib
);

  // Compare against each legal index so out-of-range selects resolve to 0
  // instead of reading past the top of the word.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (sel == IDX_W'(i)) nib = word[4*i +: 4];
    end
  end

endmodule

// File: rtl/nibble_seq.sv
// nibble_seq
// Feeds wide operands through a single 4-bit ALU one nibble per cycle,
// least significant first, chaining the carry for additions and assembling
// the wide result plus whole-word flags.
// Optional feature: define SEQ_OVF_EN to add a signed-overflow flag (ovf).
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start                 request strobe, honoured in IDLE or DONE only
//   x, y                  wide operands (ALU A and B)
//   op_aluop, op_l, op_cin  operation passed to the ALU, carry-in for nibble 0
//   a, b, alu_c_in, alu_op, alu_l  drive the ALU during RUN, 0 otherwise
//   alu_r, alu_c_out      ALU result nibble and carry
//   busy, done            run in progress / one-cycle completion pulse
//   result, zero, sign, c_out (, ovf)  assembled result and flags, held
module nibble_seq
  import nibble_seq_pkg::*;
#(
  parameter int  NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IDX_W   = clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   op_aluop,
  input  logic         op_l,
  input  logic         op_cin,
  output logic [3:0]   a,
  output logic [3:0]   b,
  output logic         alu_c_in,
  output logic [1:0]   alu_op,
  output logic         alu_l,
  input  logic [3:0]   alu_r,
  input  logic         alu_c_out,
  output logic         busy,
  output logic         done,
`ifdef SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic [W-1:0] result,
  output logic         zero,
  output logic         sign,
  output logic         c_out
);

  state_t             state, next_state;
  logic [W-1:0]       x_lat, y_lat;
  logic [1:0]         aluop_lat;
  logic               l_lat, cin_lat;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [3:0]         a_sel, b_sel;
  logic [W-1:0]       next_word;
  logic               chain, last, accept;

  nib_sel #(.NIBBLES(NIBBLES)) u_sel_a (.word(x_lat), .sel(idx), .nib(a_sel));
  nib_sel #(.NIBBLES(NIBBLES)) u_sel_b (.word(y_lat), .sel(idx), .nib(b_sel));

  assign chain  = !l_lat && (aluop_lat == ALUOP_ADD);
  assign last   = (idx == IDX_W'(NIBBLES - 1));
  assign accept = ((state == IDLE) || (state == DONE)) && start;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and ALU-facing outputs. The ALU inputs are forced to 0 outside
  // RUN so the ALU sees the same quiet values as after reset. Only nibble 0
  // of a chained add takes the external carry-in; later nibbles take the
  // carry captured from the previous nibble.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    a          = '0;
    b          = '0;
    alu_c_in   = 1'b0;
    alu_op     = '0;
    alu_l      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done       = (state == DONE);
        next_state = start ? RUN : IDLE;
      end
      RUN: begin
        busy     = 1'b1;
        a        = a_sel;
        b        = b_sel;
        alu_op   = aluop_lat;
        alu_l    = l_lat;
        alu_c_in = (chain && (idx != '0)) ? carry : cin_lat;
        if (last) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result word with the current ALU nibble merged in, so the whole-word
  // flags can be taken on the same edge that captures the final nibble.
  always_comb begin
    next_word = result;
    next_word[4*idx +: 4] = alu_r;
  end

  // Operand latch, nibble counter, carry register, result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_lat     <= '0;
      y_lat     <= '0;
      aluop_lat <= '0;
      l_lat     <= 1'b0;
      cin_lat   <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      sign      <= 1'b0;
      c_out     <= 1'b0;
`ifdef SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      x_lat     <= x;
      y_lat     <= y;
      aluop_lat <= op_aluop;
      l_lat     <= op_l;
      cin_lat   <= op_cin;
      idx       <= '0;
    end else if (state == RUN) begin
      result <= next_word;
      carry  <= alu_c_out;
      idx    <= idx + IDX_W'(1);
      if (last) begin
        zero  <= (next_word == '0);
        sign  <= alu_r[3];
        c_out <= alu_c_out;
`ifdef SEQ_OVF_EN
        ovf   <= chain && (x_lat[W-1] == y_lat[W-1]) && (alu_r[3] != x_lat[W-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_seq.sv
// tb_nibble_seq
// Self-checking bench for nibble_seq with a behavioural 4-bit ALU attached.
// Expected results come from whole-word arithmetic (adds) or per-nibble ALU
// evaluation (non-chained ops), plus timing checks on busy/done.
module tb_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk, reset, start;
  logic [W-1:0] x, y;
  logic [1:0]   op_aluop;
  logic         op_l, op_cin;
  logic [3:0]   a, b, alu_r;
  logic         alu_c_in, alu_l, alu_c_out;
  logic [1:0]   alu_op;
  logic         busy, done, zero, sign, c_out;
  logic [W-1:0] result;
`ifdef SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x(x), .y(y), .op_aluop(op_aluop), .op_l(op_l), .op_cin(op_cin),
    .a(a), .b(b), .alu_c_in(alu_c_in), .alu_op(alu_op), .alu_l(alu_l),
    .alu_r(alu_r), .alu_c_out(alu_c_out),
    .busy(busy), .done(done),
`ifdef SEQ_OVF_EN
    .ovf(ovf),
`endif
    .result(result), .zero(zero), .sign(sign), .c_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit ALU: l=0 arithmetic (00 A+cin, 01 A-B style A+~B+cin, 10 A+B+cin,
  // 11 B+cin); l=1 logic (AND, OR, XOR, NOT A) with carry 0.
  function automatic logic [4:0] alu_fn(input logic [3:0] fa, input logic [3:0] fb,
                                        input logic [1:0] fop, input logic fl,
                                        input logic fcin);
    logic [4:0] res;
    if (!fl) begin
      case (fop)
        2'b00:   res = {1'b0, fa} + 5'(fcin);
        2'b01:   res = {1'b0, fa} + {1'b0, ~fb} + 5'(fcin);
        2'b10:   res = {1'b0, fa} + {1'b0, fb} + 5'(fcin);
        default: res = {1'b0, fb} + 5'(fcin);
      endcase
    end else begin
      case (fop)
        2'b00:   res = {1'b0, fa & fb};
        2'b01:   res = {1'b0, fa | fb};
        2'b10:   res = {1'b0, fa ^ fb};
        default: res = {1'b0, ~fa};
      endcase
    end
    return res;
  endfunction

  assign {alu_c_out, alu_r} = alu_fn(a, b, alu_op, alu_l, alu_c_in);

  always @(posedge clk) begin
    if (busy) busy_cycles++;
    if (done) done_pulses++;
  end

  // Reference: adds are one wide sum; anything else is nibble-independent
  // with the last nibble's carry reported.
  function automatic void model(input logic [W-1:0] mx, input logic [W-1:0] my,
                                input logic [1:0] mop, input logic ml, input logic mcin,
                                output logic [W-1:0] mres, output logic mc,
                                output logic mz, output logic ms, output logic mo);
    logic [W:0] sum;
    logic [4:0] nr;
    mo = 1'b0;
    if (!ml && mop == 2'b10) begin
      sum  = {1'b0, mx} + {1'b0, my} + (W+1)'(mcin);
      mres = sum[W-1:0];
      mc   = sum[W];
      mo   = (mx[W-1] == my[W-1]) && (mres[W-1] != mx[W-1]);
    end else begin
      mres = '0;
      mc   = 1'b0;
      for (int n = 0; n < NIBBLES; n++) begin
        nr = alu_fn(mx[4*n +: 4], my[4*n +: 4], mop, ml, mcin);
        mres[4*n +: 4] = nr[3:0];
        mc = nr[4];
      end
    end
    mz = (mres == '0);
    ms = mres[W-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] sx, input logic [W-1:0] sy,
                               input logic [1:0] sop, input logic sl, input logic scin);
    x = sx; y = sy; op_aluop = sop; op_l = sl; op_cin = scin;
    start = 1'b1;
    busy_cycles = 0;
    done_pulses = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int start_edges, output int edges);
    edges = start_edges;
    while (done !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic compareModel(input string tag, input logic [W-1:0] mx, input logic [W-1:0] my,
                              input logic [1:0] mop, input logic ml, input logic mcin);
    logic [W-1:0] er;
    logic ec, ez, es, eo;
    model(mx, my, mop, ml, mcin, er, ec, ez, es, eo);
    checkOutput({tag, "_result"}, 32'(result), 32'(er));
    checkOutput({tag, "_c_out"}, 32'(c_out), 32'(ec));
    checkOutput({tag, "_zero"}, 32'(zero), 32'(ez));
    checkOutput({tag, "_sign"}, 32'(sign), 32'(es));
`ifdef SEQ_OVF_EN
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("[TB] unexpected unknown overflow in model");
`endif
  endtask

  task automatic doOp(input string tag, input logic [W-1:0] sx, input logic [W-1:0] sy,
                      input logic [1:0] sop, input logic sl, input logic scin);
    int e;
    applyStimulus(sx, sy, sop, sl, scin);
    waitDone(0, e);
    checkOutput({tag, "_latency"}, 32'(e), 32'd4);
    compareModel(tag, sx, sy, sop, sl, scin);
    @(posedge clk); #1;
    checkOutput({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    logic [W-1:0] rx, ry;
    logic [1:0] rop;
    logic rl, rc;

    reset = 1'b1; start = 1'b0; x = '0; y = '0;
    op_aluop = '0; op_l = 1'b0; op_cin = 1'b0;
    #12;
    checkOutput("reset_ctrl", {22'd0, busy, done, zero, sign, c_out, alu_c_in, alu_op, alu_l}, 32'd0);
    checkOutput("reset_ab", {24'd0, a, b}, 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Chained add with carry ripple across nibbles.
    applyStimulus(16'h00FF, 16'h0001, 2'b10, 1'b0, 1'b0);
    checkOutput("add_busy_start", 32'(busy), 32'd1);
    waitDone(0, e);
    checkOutput("add_latency", 32'(e), 32'd4);
    checkOutput("add_busy_cycles", 32'(busy_cycles), 32'd4);
    checkOutput("add_result_const", 32'(result), 32'h0100);
    compareModel("add", 16'h00FF, 16'h0001, 2'b10, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("add_done_pulses", 32'(done_pulses), 32'd1);
    checkOutput("add_hold_result", 32'(result), 32'h0100);

    // Wrap-around to zero.
    doOp("wrap", 16'hFFFF, 16'h0001, 2'b10, 1'b0, 1'b0);
    checkOutput("wrap_zero_const", {30'd0, zero, c_out}, 32'd3);

    // Non-chained increment: every nibble gets op_cin, no ripple.
    doOp("inc", 16'h0F0F, 16'h0000, 2'b00, 1'b0, 1'b1);
    checkOutput("inc_result_const", 32'(result), 32'h1010);

    // Start while busy is ignored; operands stay latched.
    applyStimulus(16'h00FF, 16'h0001, 2'b10, 1'b0, 1'b0);
    @(posedge clk); #1;
    x = 16'h1234; y = 16'h4321; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(2, e);
    checkOutput("busystart_latency", 32'(e), 32'd4);
    checkOutput("busystart_busy_cycles", 32'(busy_cycles), 32'd4);
    compareModel("busystart", 16'h00FF, 16'h0001, 2'b10, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset during nibble 2 aborts without a done pulse.
    applyStimulus(16'h1357, 16'h2468, 2'b10, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", {30'd0, busy, done}, 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_alu", {24'd0, a, alu_c_in, alu_op, alu_l}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_pulses = 0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_pulses), 32'd0);
    doOp("after_abort", 16'h1357, 16'h2468, 2'b10, 1'b0, 1'b1);

    // Back-to-back runs with start held high.
    x = 16'h1111; y = 16'h2222; op_aluop = 2'b10; op_l = 1'b0; op_cin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    x = 16'hABCD; y = 16'h9876;
    waitDone(0, e);
    checkOutput("b2b_first_latency", 32'(e), 32'd4);
    compareModel("b2b_first", 16'h1111, 16'h2222, 2'b10, 1'b0, 1'b1);
    x = 16'h8001; y = 16'h8001; op_cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b_no_idle", 32'(busy), 32'd1);
    waitDone(1, e);
    checkOutput("b2b_second_spacing", 32'(e), 32'd5);
    compareModel("b2b_second", 16'h8001, 16'h8001, 2'b10, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Signed overflow case.
    doOp("ovf", 16'h7FFF, 16'h0001, 2'b10, 1'b0, 1'b0);
    checkOutput("ovf_sign_const", 32'(sign), 32'd1);

    // Randomized operations, biased toward chained adds.
    for (int i = 0; i < 24; i++) begin
      rx  = W'($urandom);
      ry  = W'($urandom);
      rop = 2'($urandom_range(0, 3));
      rl  = 1'($urandom_range(0, 1));
      rc  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        rop = 2'b10;
        rl  = 1'b0;
      end
      doOp("rand", rx, ry, rop, rl, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_seq.md
# nibble_seq

Multi-cycle operand sequencer placed directly upstream of the 4-bit ALU stage. It takes wide operands and a single ALU operation, then presents them one nibble per cycle on the ALU inputs, least significant nibble first. It consumes each 4-bit ALU result and carry, chains the carry across nibbles for addition, and assembles the wide result with whole-word flags. This gives the datapath N×4-bit arithmetic and logic from one 4-bit ALU instance.

## Interface
- NIBBLES, 4, number of 4-bit slices; word width W = 4*NIBBLES.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE or DONE.
- x  in  W  operand routed to ALU input A.
- y  in  W  operand routed to ALU input B.
- op_aluop  in  2  operation code, passed unchanged to ALU ALUOP.
- op_l  in  1  logic/arithmetic select, passed unchanged to ALU l.
- op_cin  in  1  carry-in for nibble 0, and for every nibble when not chaining.
- a, b  out  4  current nibble of the latched x and y.
- alu_c_in  out  1  to ALU c_in.
- alu_op  out  2  to ALU ALUOP.
- alu_l  out  1  to ALU l.
- alu_r  in  4  ALU result R.
- alu_c_out  in  1  ALU carry out.
- busy  out  1  high while nibbles are being issued.
- done  out  1  one-cycle completion pulse.
- result  out  W  assembled result; held until the next accepted start.
- zero, sign, c_out  out  1  whole-word flags; held alongside result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1: latch x, y, op_aluop, op_l, op_cin; clear the nibble index; go to RUN.
- IDLE or DONE with start=0: go to IDLE.
- RUN, nibble index k:
  - a = x_lat[4k+3:4k] and b = y_lat[4k+3:4k].
  - alu_op and alu_l come from the latched values.
  - At the clock edge, alu_r is written to result[4k+3:4k] and alu_c_out is stored in the carry register.
- Chain mode is active only when op_l=0 and op_aluop=2'b10 (add).
  - Nibble 0 uses alu_c_in = op_cin_lat.
  - Nibble k>0 uses alu_c_in = the carry register.
- Outside chain mode, every nibble uses op_cin_lat and each nibble's carry is discarded, except the last one.
- After the last nibble (k = NIBBLES-1), go to DONE.
  - zero = (assembled result == 0).
  - sign = result[W-1].
  - c_out = carry of the last nibble.
- start during RUN is ignored. Latched operands do not change mid-run.
- Reset values:
  - state IDLE; result, zero, sign and c_out all 0.
  - busy=0 and done=0.
  - a, b, alu_c_in, alu_op and alu_l all 0.

## Timing
- start sampled at edge E0. Nibble k result is captured at edge E(k+1).
- busy=1 from E0 until E(NIBBLES). done=1 for exactly one cycle after E(NIBBLES).
- Latency is NIBBLES edges from start to done; a run followed by done occupies NIBBLES+1 cycles.
- result and flags become valid when done rises. They stay stable through IDLE.
- A start sampled in the DONE cycle begins the next run with no idle cycle.
- The ALU path is combinational: alu_r and alu_c_out must settle within the same cycle.
- Reset asserted mid-run aborts immediately: no done pulse, and all outputs return to their reset values.

## Configuration
- SEQ_OVF_EN defined:
  - Adds output `ovf` (1 bit, reset 0), updated with the other flags.
  - In chain mode, ovf=1 when x_lat[W-1]==y_lat[W-1] and result[W-1]!=x_lat[W-1]; otherwise ovf=0.
  - Requires one extra register and no change to latency.
- SEQ_OVF_EN undefined: no ovf port and no overflow logic.

## Structure
- Shared package `nibble_seq_pkg`:
  - state enum {IDLE, RUN, DONE};
  - constant ALUOP_ADD = 2'b10;
  - nibble-index width function clog2(NIBBLES).
- One sub-module, `nib_sel`: a NIBBLES-to-1 4-bit slice mux, instantiated for a and for b.
- Counter, carry register and flag logic stay in the top module.

## Test plan
- Chained add: x=16'h00FF, y=16'h0001, op_l=0, op_aluop=10, op_cin=0 -> result 16'h0100, c_out=0, zero=0; done high exactly 4 edges after start.
- Wrap-around: x=16'hFFFF, y=16'h0001, add -> result 16'h0000, zero=1, c_out=1, sign=0.
- Non-chained op: x=16'h0F0F, op_l=0, op_aluop=00, op_cin=1 -> each nibble is A+1, result 16'h1010; nibble-0 carry is not propagated.
- start while busy: second start at cycle 2 with x=16'h1234 -> result matches the first request; busy stays high for exactly 4 cycles.
- Reset mid-run: assert reset during nibble 2 -> busy=0, result=0, no done pulse; the next start completes normally.
- Back-to-back: start held high through DONE -> second run begins with no idle cycle, and done pulses again 5 edges after the first pulse. With SEQ_OVF_EN, 16'h7FFF+16'h0001 gives ovf=1 and sign=1.
